ddr_write_control: RTL and testbench

DDR_WRITE_CONTROL -- requirements
Module: ddr_write_control

---
 rtl/ddr_if_pkg.sv | 16 +
 rtl/ddr_write_control.sv | 147 ++++++++++++++
 tb/tb_ddr_write_control.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_if_pkg.sv
// Shared DDR user-interface definitions: command encodings and the write
// controller state type.
package ddr_if_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ISSUE,
        ST_FIN
    } wr_state_e;

endpackage

// File: rtl/ddr_write_control.sv
// DDR write-back controller: pops result words from an upstream FIFO and
// writes them to the memory controller one beat per burst at consecutive
// addresses, with independent command and write-data handshakes.
// Optional feature: define DDR_WR_STALL_CNT_EN to add the stall_cnt output.
module ddr_write_control
    import ddr_if_pkg::*;
#(
    parameter int APP_DATA_WIDTH = 512,
    parameter int APP_ADDR_WIDTH = 29,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int DM_WIDTH       = 8,
    parameter int DDR_ADDR_LEN   = 32,
    parameter int SINGLE_LEN     = 24,
    parameter int ADDR_INC       = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_calib_complete,
    input  logic [DDR_ADDR_LEN-1:0]            ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]              ddr_len,
    input  logic                               ddr_conf,
    input  logic                               wr_fifo_empty,
    output logic                               wr_fifo_req,
    input  logic [APP_DATA_WIDTH-1:0]          wr_fifo_data,
    input  logic                               app_rdy,
    input  logic                               app_wdf_rdy,
    output logic [APP_CMD_WIDTH-1:0]           app_cmd,
    output logic [APP_ADDR_WIDTH-1:0]          app_addr,
    output logic                               app_en,
    output logic [APP_DATA_WIDTH-1:0]          app_wdf_data,
    output logic [APP_DATA_WIDTH/DM_WIDTH-1:0] app_wdf_mask,
    output logic                               app_wdf_wren,
    output logic                               app_wdf_end,
`ifdef DDR_WR_STALL_CNT_EN
    output logic [31:0]                        stall_cnt,
`endif
    output logic                               idle,
    output logic                               done
);

    wr_state_e                 state_q;
    logic [APP_ADDR_WIDTH-1:0] addr_q;
    logic [SINGLE_LEN-1:0]     len_q;
    logic [SINGLE_LEN-1:0]     beat_q;
    logic [APP_DATA_WIDTH-1:0] wdata_q;
    logic                      en_q;
    logic                      wren_q;
    logic                      done_q;

    logic cmd_ok;
    logic dat_ok;
    logic beat_done;
    logic last_beat;
    logic conf_ok;

    // Only the low address bits reach the controller; the rest is dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ddr_st_addr[DDR_ADDR_LEN-1:APP_ADDR_WIDTH];

    // A side is finished once its enable has been accepted, including this cycle.
    assign cmd_ok    = !en_q || app_rdy;
    assign dat_ok    = !wren_q || app_wdf_rdy;
    assign beat_done = (state_q == ST_ISSUE) && cmd_ok && dat_ok;
    assign last_beat = (beat_q + SINGLE_LEN'(1)) == len_q;
    assign conf_ok   = (state_q == ST_IDLE) && ddr_conf && init_calib_complete;

    // Transfer sequencing, beat addressing and both app-side handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (conf_ok) begin
                        addr_q  <= ddr_st_addr[APP_ADDR_WIDTH-1:0];
                        len_q   <= ddr_len;
                        beat_q  <= '0;
                        state_q <= (ddr_len == '0) ? ST_FIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // The pop itself is combinational so it lands in the entry cycle.
                    if (!wr_fifo_empty) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    wdata_q <= wr_fifo_data;
                    en_q    <= 1'b1;
                    wren_q  <= 1'b1;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (app_rdy)     en_q   <= 1'b0;
                    if (app_wdf_rdy) wren_q <= 1'b0;
                    if (beat_done) begin
                        beat_q  <= beat_q + SINGLE_LEN'(1);
                        addr_q  <= addr_q + APP_ADDR_WIDTH'(ADDR_INC);
                        state_q <= last_beat ? ST_FIN : ST_FETCH;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR_WR_STALL_CNT_EN
    logic [31:0] stall_q;

    // Cycles in ISSUE where some still-pending enable is back-pressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (conf_ok) begin
            stall_q <= '0;
        end else if ((state_q == ST_ISSUE) &&
                     ((en_q && !app_rdy) || (wren_q && !app_wdf_rdy)) &&
                     (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign wr_fifo_req  = (state_q == ST_FETCH) && !wr_fifo_empty;
    assign app_cmd      = APP_CMD_WIDTH'(CMD_WRITE);
    assign app_addr     = addr_q;
    assign app_en       = en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = '0;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign idle         = (state_q == ST_IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_ddr_write_control.sv
// Self-checking bench for ddr_write_control: table of transfers plus
// hand-written sequences for len=0, calibration gating and mid-transfer reset.
module tb_ddr_write_control;

    localparam int DW = 512;
    localparam int AW = 29;
    localparam int CW = 3;
    localparam int MW = DW / 8;
    localparam int AL = 32;
    localparam int LL = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_calib_complete = 1'b0;
    logic [AL-1:0] ddr_st_addr = '0;
    logic [LL-1:0] ddr_len = '0;
    logic          ddr_conf = 1'b0;
    logic          wr_fifo_empty = 1'b1;
    logic          wr_fifo_req;
    logic [DW-1:0] wr_fifo_data = '0;
    logic          app_rdy = 1'b1;
    logic          app_wdf_rdy = 1'b1;
    logic [CW-1:0] app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_en;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          idle;
    logic          done;
`ifdef DDR_WR_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    ddr_write_control dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .ddr_st_addr         (ddr_st_addr),
        .ddr_len             (ddr_len),
        .ddr_conf            (ddr_conf),
        .wr_fifo_empty       (wr_fifo_empty),
        .wr_fifo_req         (wr_fifo_req),
        .wr_fifo_data        (wr_fifo_data),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
`ifdef DDR_WR_STALL_CNT_EN
        .stall_cnt           (stall_cnt),
`endif
        .idle                (idle),
        .done                (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Upstream FIFO model: data valid the cycle after a pop.
    logic [DW-1:0] fifo[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    always @(posedge clk) begin
        if (rst_n && wr_fifo_req) begin
            if (fifo.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow pop while empty (t=%0t)", $time);
            end else begin
                wr_fifo_data <= fifo.pop_front();
                if (fifo.size() == 0) wr_fifo_empty <= 1'b1;
            end
        end
    end

    task automatic push_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        fifo.push_back(w);
        exp_data.push_back(w);
        exp_addr.push_back(a);
        wr_fifo_empty = 1'b0;
    endtask

    // Monitor statistics, cleared per sequence.
    int req_cycles, en_cycles, wren_cycles, beats_cmd, beats_dat, done_cnt, busy_cycles;
    int first_req, first_en, done_cyc, unstable;
    logic [AW-1:0] last_addr, en_addr;
    logic [DW-1:0] wren_data;
    logic en_prev, wren_prev;

    task automatic clr_stats();
        req_cycles = 0; en_cycles = 0; wren_cycles = 0; beats_cmd = 0; beats_dat = 0;
        done_cnt = 0; busy_cycles = 0; first_req = -1; first_en = -1; done_cyc = -1;
        unstable = 0; last_addr = '0; en_prev = 1'b0; wren_prev = 1'b0;
    endtask

    // Scoreboard side: compare every accepted command/data beat against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!idle) busy_cycles++;
            if (wr_fifo_req) begin
                req_cycles++;
                if (first_req < 0) first_req = cyc;
            end
            if (app_en) begin
                en_cycles++;
                if (first_en < 0) first_en = cyc;
                if (en_prev && app_addr !== en_addr) unstable++;
                en_addr = app_addr;
            end
            en_prev = app_en;
            if (app_wdf_wren) begin
                wren_cycles++;
                if (wren_prev && app_wdf_data !== wren_data) unstable++;
                wren_data = app_wdf_data;
            end
            wren_prev = app_wdf_wren;
            if (app_en && app_rdy) begin
                beats_cmd++;
                last_addr = app_addr;
                chk("app_cmd", app_cmd, 0);
                if (exp_addr.size() == 0) chk("unexpected_cmd", 1, 0);
                else chk("app_addr", app_addr, exp_addr.pop_front());
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                beats_dat++;
                chk("wdf_end", app_wdf_end, 1);
                chk("wdf_mask", app_wdf_mask, 0);
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_data beat with empty scoreboard");
                end else if (app_wdf_data !== exp_data[0]) begin
                    errors++;
                    $display("FAIL wdf_data actual=%h expected=%h", app_wdf_data[63:0], exp_data[0][63:0]);
                end
                if (exp_data.size() != 0) void'(exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic conf(input logic [AL-1:0] a, input int len, input logic calib);
        @(posedge clk); #1;
        ddr_st_addr = a;
        ddr_len = LL'(len);
        init_calib_complete = calib;
        ddr_conf = 1'b1;
        @(posedge clk); #1;
        ddr_conf = 1'b0;
        init_calib_complete = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) chk({nm, "_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sig(input bit want_en, input int max);
        int n = 0;
        while (!(want_en ? app_en : app_wdf_wren) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) chk("enable_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_idle", idle, 1);
        chk("rst_app_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_wdf_end", app_wdf_end, 0);
        chk("rst_fifo_req", wr_fifo_req, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", app_addr, 0);
        chk("rst_data_lo", app_wdf_data[63:0], 0);
        chk("rst_cmd", app_cmd, 0);
        chk("rst_mask", app_wdf_mask, 0);
    endtask

    typedef struct {
        logic [AL-1:0] addr;
        int            len;
        int            rdy_stall;
        int            wdf_stall;
        int            fifo_delay;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[5];
    int conf_cyc;

    task automatic run_vec(input vec_t v);
        logic [AW-1:0] a;
        clr_stats();
        app_rdy = (v.rdy_stall == 0);
        app_wdf_rdy = (v.wdf_stall == 0);
        a = v.addr[AW-1:0];
        if (v.fifo_delay == 0)
            for (int i = 0; i < v.len; i++) begin
                push_word(a);
                a = a + AW'(8);
            end
        @(posedge clk); #1;
        conf_cyc = cyc + 1;
        conf(v.addr, v.len, 1'b1);
        if (v.fifo_delay > 0) begin
            repeat (3) @(posedge clk);
            conf(32'h900, 5, 1'b1);   // must be ignored: controller is busy
            repeat (v.fifo_delay - 5) @(posedge clk);
            #1;
            chk("empty_no_req", req_cycles, 0);
            chk("empty_no_en", en_cycles, 0);
            for (int i = 0; i < v.len; i++) begin
                push_word(a);
                a = a + AW'(8);
            end
        end
        if (v.rdy_stall > 0) begin
            wait_sig(1'b1, 50);
            repeat (v.rdy_stall) @(posedge clk);
            #1 app_rdy = 1'b1;
        end
        if (v.wdf_stall > 0) begin
            wait_sig(1'b0, 50);
            repeat (v.wdf_stall) @(posedge clk);
            #1 app_wdf_rdy = 1'b1;
        end
        wait_done("xfer", 300);
        chk("beats_cmd", beats_cmd, v.len);
        chk("beats_dat", beats_dat, v.len);
        chk("last_addr", last_addr, v.exp_last);
        chk("done_pulses", done_cnt, 1);
        chk("fifo_reqs", req_cycles, v.len);
        chk("en_cycles", en_cycles, v.len + v.rdy_stall);
        chk("wren_cycles", wren_cycles, v.len + v.wdf_stall);
        chk("unstable", unstable, 0);
        chk("sb_left", exp_addr.size() + exp_data.size(), 0);
        chk("idle_after", idle, 1);
        if (v.fifo_delay == 0) begin
            chk("lat_req", first_req - conf_cyc, 1);
            chk("lat_en", first_en - conf_cyc, 3);
        end
`ifdef DDR_WR_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, v.rdy_stall + v.wdf_stall);
`endif
    endtask

    initial begin
        vecs[0] = '{32'h100,      4, 0, 0, 0,  29'h118};
        vecs[1] = '{32'h200,      1, 5, 0, 0,  29'h200};
        vecs[2] = '{32'h300,      2, 0, 0, 10, 29'h308};
        vecs[3] = '{32'h1FFFFFF8, 2, 0, 0, 0,  29'h0};
        vecs[4] = '{32'h40,       3, 0, 3, 0,  29'h50};

        clr_stats();
        #3;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        init_calib_complete = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // len=0: straight to FIN, done two cycles after conf, nothing issued.
        clr_stats();
        @(posedge clk); #1;
        conf_cyc = cyc + 1;
        conf(32'h600, 0, 1'b1);
        wait_done("len0", 20);
        chk("len0_done_lat", done_cyc - conf_cyc, 2);
        chk("len0_en", en_cycles + wren_cycles, 0);
        chk("len0_done_cnt", done_cnt, 1);

        // Calibration incomplete: conf ignored.
        clr_stats();
        push_word(29'h500);
        conf(32'h500, 1, 1'b0);
        repeat (6) @(negedge clk);
        chk("nocal_busy", busy_cycles, 0);
        chk("nocal_req", req_cycles, 0);
        chk("nocal_done", done_cnt, 0);
        fifo.delete(); exp_addr.delete(); exp_data.delete();
        wr_fifo_empty = 1'b1;

        // Reset during ISSUE of beat 2 of 4.
        clr_stats();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) push_word(AW'(32'h700 + i * 8));
        conf(32'h700, 4, 1'b1);
        begin
            int n = 0;
            while (!(app_en && beats_cmd == 1) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("beat2_reached", beats_cmd, 1);
        end
        #1 rst_n = 1'b0;
        #1 chk_reset_vals();
        fifo.delete(); exp_addr.delete(); exp_data.delete();
        wr_fifo_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle_after", idle, 1);

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
